rdrsp_nr2w_ecc_1r1w: RTL

- Read-side client adapter directly downstream of the nr2w ECC 1r1w memory; one lane per read port.
- Gates client read requests with per-port credits so memory responses never overflow local storage, since the memory read port has no backpressure.
- Buffers each response (data, fwrd, serr, derr, padr) in a per-port FIFO with valid/ready output handshake.
- Keeps global saturating ECC error counters and a first-double-error log for software.

---
 rtl/rdrsp_nr2w_pkg.sv | 28 ++
 rtl/rdrsp_nr2w_ecc_1r1w_lane.sv | 75 +++++++
 rtl/rdrsp_nr2w_ecc_1r1w.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rdrsp_nr2w_pkg.sv
// rtl/rdrsp_nr2w_pkg.sv - shared response entry type, counter limits and saturating add
package rdrsp_nr2w_pkg;

    localparam int RSP_WIDTH   = 32;
    localparam int RSP_BITPADR = 14;
    localparam int CNT_W       = 16;
    localparam int PORT_W      = 1;
    localparam int SUM_W       = CNT_W + PORT_W + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [RSP_WIDTH-1:0]   data;
        logic                   fwrd;
        logic                   serr;
        logic                   derr;
        logic [RSP_BITPADR-1:0] padr;
    } rsp_entry_t;

    // Widen before adding so a multi-lane increment near the top cannot wrap.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [PORT_W:0]  inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt) + SUM_W'(inc);
        sat_add = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/rdrsp_nr2w_ecc_1r1w_lane.sv
// rtl/rdrsp_nr2w_ecc_1r1w_lane.sv - per-lane credit counter and first-word fall-through response FIFO
module rdrsp_lane_fifo
    import rdrsp_nr2w_pkg::*;
#(
    parameter int FIFODEP = 4,
    parameter int BITFIFO = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cl_read,
    input  logic       ready,
    output logic       cl_gnt,
    input  logic       rd_vld,
    input  rsp_entry_t rd_rsp,
    output logic       rsp_acc,
    output logic       rsp_unexp,
    output logic       cl_vld,
    input  logic       cl_rdy,
    output rsp_entry_t cl_rsp
);

    localparam logic [BITFIFO:0] DEP = (BITFIFO+1)'(FIFODEP);

    rsp_entry_t           mem_q [FIFODEP];
    rsp_entry_t           mem_d [FIFODEP];
    logic [BITFIFO-1:0]   wptr_q, wptr_d;
    logic [BITFIFO-1:0]   rptr_q, rptr_d;
    logic [BITFIFO:0]     cnt_q, cnt_d;
    logic [BITFIFO:0]     cred_q, cred_d;
    logic [BITFIFO:0]     outst;
    logic                 pop;

    always_comb begin
        // Requests in flight are whatever the credit pool and FIFO do not account for.
        outst     = DEP - cred_q - cnt_q;
        cl_gnt    = rst & cl_read & ready & (cred_q != '0);
        rsp_acc   = rd_vld & (outst != '0);
        rsp_unexp = rd_vld & (outst == '0);
        cl_vld    = (cnt_q != '0);
        pop       = cl_vld & cl_rdy;
        cl_rsp    = cl_vld ? mem_q[rptr_q] : '0;

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (rsp_acc) begin
            mem_d[wptr_q] = rd_rsp;
            wptr_d        = wptr_q + BITFIFO'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + BITFIFO'(1);
        end
        cnt_d  = cnt_q + (BITFIFO+1)'(rsp_acc) - (BITFIFO+1)'(pop);
        cred_d = cred_q - (BITFIFO+1)'(cl_gnt) + (BITFIFO+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFODEP; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            cred_q <= DEP;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            cred_q <= cred_d;
        end
    end

endmodule

// File: rtl/rdrsp_nr2w_ecc_1r1w.sv
// rtl/rdrsp_nr2w_ecc_1r1w.sv - credit-gated read response adapter with ECC error counters and log
module rdrsp_nr2w_ecc_1r1w
    import rdrsp_nr2w_pkg::*;
#(
    parameter int NUMRDPT = 2,
    parameter int WIDTH   = RSP_WIDTH,
    parameter int BITADDR = 13,
    parameter int BITPADR = RSP_BITPADR,
    parameter int FIFODEP = 4,
    parameter int BITFIFO = 2,
    parameter int BITCNT  = CNT_W,
    parameter int BITPORT = PORT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUMRDPT-1:0]         cl_read,
    input  logic [NUMRDPT*BITADDR-1:0] cl_rd_adr,
    output logic [NUMRDPT-1:0]         cl_gnt,
    output logic [NUMRDPT-1:0]         read,
    output logic [NUMRDPT*BITADDR-1:0] rd_adr,
    input  logic                       ready,
    input  logic [NUMRDPT-1:0]         rd_vld,
    input  logic [NUMRDPT*WIDTH-1:0]   rd_dout,
    input  logic [NUMRDPT-1:0]         rd_fwrd,
    input  logic [NUMRDPT-1:0]         rd_serr,
    input  logic [NUMRDPT-1:0]         rd_derr,
    input  logic [NUMRDPT*BITPADR-1:0] rd_padr,
    output logic [NUMRDPT-1:0]         cl_vld,
    input  logic [NUMRDPT-1:0]         cl_rdy,
    output logic [NUMRDPT*WIDTH-1:0]   cl_dout,
    output logic [NUMRDPT-1:0]         cl_fwrd,
    output logic [NUMRDPT-1:0]         cl_serr,
    output logic [NUMRDPT-1:0]         cl_derr,
    output logic [NUMRDPT*BITPADR-1:0] cl_padr,
    input  logic                       err_clr,
    output logic [BITCNT-1:0]          serr_cnt,
    output logic [BITCNT-1:0]          derr_cnt,
    output logic                       log_vld,
    output logic [BITPORT-1:0]         log_port,
    output logic [BITPADR-1:0]         log_padr,
    output logic [NUMRDPT-1:0]         ovfl
);

    rsp_entry_t         rd_rsp [NUMRDPT];
    rsp_entry_t         cl_rsp [NUMRDPT];
    logic [NUMRDPT-1:0] rsp_acc;
    logic [NUMRDPT-1:0] rsp_unexp;

    assign read   = cl_gnt;
    assign rd_adr = cl_rd_adr;

    for (genvar p = 0; p < NUMRDPT; p++) begin : g_lane
        assign rd_rsp[p] = '{data: rd_dout[p*WIDTH +: WIDTH],
                             fwrd: rd_fwrd[p],
                             serr: rd_serr[p],
                             derr: rd_derr[p],
                             padr: rd_padr[p*BITPADR +: BITPADR]};

        rdrsp_lane_fifo #(
            .FIFODEP (FIFODEP),
            .BITFIFO (BITFIFO)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .cl_read   (cl_read[p]),
            .ready     (ready),
            .cl_gnt    (cl_gnt[p]),
            .rd_vld    (rd_vld[p]),
            .rd_rsp    (rd_rsp[p]),
            .rsp_acc   (rsp_acc[p]),
            .rsp_unexp (rsp_unexp[p]),
            .cl_vld    (cl_vld[p]),
            .cl_rdy    (cl_rdy[p]),
            .cl_rsp    (cl_rsp[p])
        );

        assign cl_dout[p*WIDTH +: WIDTH]     = cl_rsp[p].data;
        assign cl_fwrd[p]                    = cl_rsp[p].fwrd;
        assign cl_serr[p]                    = cl_rsp[p].serr;
        assign cl_derr[p]                    = cl_rsp[p].derr;
        assign cl_padr[p*BITPADR +: BITPADR] = cl_rsp[p].padr;
    end

    logic [BITCNT-1:0]  serr_cnt_q, serr_cnt_d;
    logic [BITCNT-1:0]  derr_cnt_q, derr_cnt_d;
    logic               log_vld_q, log_vld_d;
    logic [BITPORT-1:0] log_port_q, log_port_d;
    logic [BITPADR-1:0] log_padr_q, log_padr_d;
    logic [NUMRDPT-1:0] ovfl_q, ovfl_d;

    logic [BITPORT:0]   serr_inc, derr_inc;
    logic               derr_hit;
    logic [BITPORT-1:0] derr_port;
    logic [BITPADR-1:0] derr_padr;

    always_comb begin
        serr_inc  = '0;
        derr_inc  = '0;
        derr_hit  = 1'b0;
        derr_port = '0;
        derr_padr = '0;
        // Dropped stragglers never reach the counters; lowest lane wins the log.
        for (int p = 0; p < NUMRDPT; p++) begin
            serr_inc = serr_inc + (BITPORT+1)'(rsp_acc[p] & rd_serr[p]);
            derr_inc = derr_inc + (BITPORT+1)'(rsp_acc[p] & rd_derr[p]);
            if (!derr_hit && rsp_acc[p] && rd_derr[p]) begin
                derr_hit  = 1'b1;
                derr_port = BITPORT'(p);
                derr_padr = rd_padr[p*BITPADR +: BITPADR];
            end
        end

        serr_cnt_d = serr_cnt_q;
        derr_cnt_d = derr_cnt_q;
        log_vld_d  = log_vld_q;
        log_port_d = log_port_q;
        log_padr_d = log_padr_q;
        ovfl_d     = ovfl_q;
        if (err_clr) begin
            serr_cnt_d = '0;
            derr_cnt_d = '0;
            log_vld_d  = 1'b0;
            log_port_d = '0;
            log_padr_d = '0;
            ovfl_d     = '0;
        end else begin
            serr_cnt_d = sat_add(serr_cnt_q, serr_inc);
            derr_cnt_d = sat_add(derr_cnt_q, derr_inc);
            ovfl_d     = ovfl_q | rsp_unexp;
            if (!log_vld_q && derr_hit) begin
                log_vld_d  = 1'b1;
                log_port_d = derr_port;
                log_padr_d = derr_padr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            serr_cnt_q <= '0;
            derr_cnt_q <= '0;
            log_vld_q  <= 1'b0;
            log_port_q <= '0;
            log_padr_q <= '0;
            ovfl_q     <= '0;
        end else begin
            serr_cnt_q <= serr_cnt_d;
            derr_cnt_q <= derr_cnt_d;
            log_vld_q  <= log_vld_d;
            log_port_q <= log_port_d;
            log_padr_q <= log_padr_d;
            ovfl_q     <= ovfl_d;
        end
    end

    assign serr_cnt = serr_cnt_q;
    assign derr_cnt = derr_cnt_q;
    assign log_vld  = log_vld_q;
    assign log_port = log_port_q;
    assign log_padr = log_padr_q;
    assign ovfl     = ovfl_q;

endmodule
